// File: rtl/fifo_burst_reader_if.sv
// Read side of the upstream FIFO plus the outgoing burst stream, bundled as one port.
interface fifo_burst_reader_if #(
  parameter int WIDTH = 32
);
  logic             fifo_re;
  logic [WIDTH-1:0] fifo_dout;
  logic             fifo_empty;
  logic [WIDTH-1:0] fifo_count;
  logic [WIDTH-1:0] m_data;
  logic             m_valid;
  logic             m_last;
  logic             m_ready;

  modport master (
    output fifo_re, m_data, m_valid, m_last,
    input  fifo_dout, fifo_empty, fifo_count, m_ready
  );

  modport slave (
    input  fifo_re, m_data, m_valid, m_last,
    output fifo_dout, fifo_empty, fifo_count, m_ready
  );
endinterface

// File: rtl/fifo_burst_reader.sv
// Drains a FIFO into fixed-length valid/ready bursts (short tail on flush); first word 3 cycles after count qualifies.
// Under backpressure a 2-entry buffer caps outstanding words at 2 and holds head data stable until accepted.
module fifo_burst_reader #(
  parameter int WIDTH     = 32,
  parameter int BURST_LEN = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  fifo_burst_reader_if.master  bus,
  input  logic                 flush,
  output logic                 busy,
  output logic [15:0]          burst_done
);

  typedef enum logic {IDLE, BURST} state_e;

  localparam logic [7:0]       BL  = 8'(BURST_LEN);
  localparam logic [WIDTH-1:0] BLW = WIDTH'(BURST_LEN);

  state_e           state_q, state_d;
  logic [7:0]       rd_left_q, rd_left_d;
  logic [7:0]       len_q, len_d;
  logic [7:0]       wr_idx_q, wr_idx_d;
  logic [1:0]       occ_q, occ_d;
  logic             inflight_q;
  logic [WIDTH-1:0] buf0_q, buf0_d, buf1_q, buf1_d;
  logic             flush_pend_q, flush_pend_d;
  logic [15:0]      burst_done_q, burst_done_d;
  logic             re, pop, last;

  always_comb begin
    pop  = (occ_q != 2'd0) && bus.m_ready;
    last = (wr_idx_q == len_q - 8'd1);
    // Reserve a buffer slot for every word already requested but not yet captured.
    re   = (state_q == BURST) && (rd_left_q != 8'd0) && !bus.fifo_empty &&
           (({1'b0, occ_q} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop}));
  end

  always_comb begin
    state_d      = state_q;
    rd_left_d    = rd_left_q;
    len_d        = len_q;
    wr_idx_d     = wr_idx_q;
    flush_pend_d = flush_pend_q;
    burst_done_d = burst_done_q;
    case (state_q)
      IDLE: begin
        if (bus.fifo_count >= BLW) begin
          state_d   = BURST;
          rd_left_d = BL;
          len_d     = BL;
          wr_idx_d  = 8'd0;
        end else if (flush_pend_q && (bus.fifo_count != '0)) begin
          state_d      = BURST;
          rd_left_d    = bus.fifo_count[7:0];
          len_d        = bus.fifo_count[7:0];
          wr_idx_d     = 8'd0;
          flush_pend_d = 1'b0;
        end else if (bus.fifo_count == '0) begin
          flush_pend_d = 1'b0;
        end
      end
      BURST: begin
        if (re) rd_left_d = rd_left_q - 8'd1;
        if (pop) begin
          wr_idx_d = wr_idx_q + 8'd1;
          if (last) begin
            state_d      = IDLE;
            burst_done_d = burst_done_q + 16'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush) flush_pend_d = 1'b1;
  end

  always_comb begin
    buf0_d = buf0_q;
    buf1_d = buf1_q;
    occ_d  = occ_q;
    case ({inflight_q, pop})
      2'b11: begin
        if (occ_q == 2'd1) begin
          buf0_d = bus.fifo_dout;
        end else begin
          buf0_d = buf1_q;
          buf1_d = bus.fifo_dout;
        end
      end
      2'b01: begin
        buf0_d = buf1_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b10: begin
        if (occ_q == 2'd0) buf0_d = bus.fifo_dout;
        else               buf1_d = bus.fifo_dout;
        occ_d = occ_q + 2'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      rd_left_q    <= 8'd0;
      len_q        <= 8'd0;
      wr_idx_q     <= 8'd0;
      occ_q        <= 2'd0;
      inflight_q   <= 1'b0;
      buf0_q       <= '0;
      buf1_q       <= '0;
      flush_pend_q <= 1'b0;
      burst_done_q <= 16'd0;
    end else begin
      state_q      <= state_d;
      rd_left_q    <= rd_left_d;
      len_q        <= len_d;
      wr_idx_q     <= wr_idx_d;
      occ_q        <= occ_d;
      inflight_q   <= re;
      buf0_q       <= buf0_d;
      buf1_q       <= buf1_d;
      flush_pend_q <= flush_pend_d;
      burst_done_q <= burst_done_d;
    end
  end

  assign bus.fifo_re = re;
  assign bus.m_valid = (occ_q != 2'd0);
  assign bus.m_last  = (occ_q != 2'd0) && last;
  assign bus.m_data  = buf0_q;
  assign busy        = (state_q == BURST);
  assign burst_done  = burst_done_q;

endmodule
